// File: rtl/dm_responder.sv
// Fixed-latency word-addressed data memory responder with byte-enable writes.
// Define DM_RESPONDER_BACK2BACK_EN to let a new request be captured on the response handshake edge.
module dm_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned ROW_LSB  = DEPTH_LOG2 + 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   ready_q;
  logic [31:0]            cap_addr;
  logic [31:0]            cap_wdata;
  logic                   cap_write;
  logic [3:0]             cap_wstrb;
  logic [31:0]            mem [DEPTH];

  logic [DEPTH_LOG2-1:0]  idx;
  logic                   addr_err;
  logic                   exec;
  logic                   accept;

  assign idx      = cap_addr[DEPTH_LOG2+1:2];
  assign addr_err = (cap_addr[1:0] != 2'b00) || ((cap_addr >> ROW_LSB) != 32'd0);
  assign exec     = (state == BUSY) && (cnt == '0);
  assign accept   = req_valid && req_ready;

`ifdef DM_RESPONDER_BACK2BACK_EN
  // In RESP the consumer's ready doubles as our request ready.
  assign req_ready = ready_q || ((state == RESP) && resp_ready);
`else
  assign req_ready = ready_q;
`endif

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ready_q    <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      cap_write  <= 1'b0;
      cap_wstrb  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_write <= req_write;
            cap_wstrb <= req_wstrb;
            cnt       <= CNT_LOAD;
            ready_q   <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= addr_err;
            resp_rdata <= (!addr_err && !cap_write) ? mem[idx] : 32'd0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
`ifdef DM_RESPONDER_BACK2BACK_EN
            if (req_valid) begin
              cap_addr  <= req_addr;
              cap_wdata <= req_wdata;
              cap_write <= req_write;
              cap_wstrb <= req_wstrb;
              cnt       <= CNT_LOAD;
              state     <= BUSY;
            end else begin
              ready_q <= 1'b1;
              state   <= IDLE;
            end
`else
            ready_q <= 1'b1;
            state   <= IDLE;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage is not reset; a reset before the execute edge returns state to IDLE so no write occurs.
  always_ff @(posedge clk) begin
    if (exec && cap_write && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_wstrb[i]) mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed vector table, reset/throughput sequences, random ops vs a word-array model.
module tb_dm_responder;

  localparam int unsigned DL  = 10;
  localparam int unsigned LAT = 2;
`ifdef DM_RESPONDER_BACK2BACK_EN
  localparam int PERIOD = LAT + 1;
`else
  localparam int PERIOD = LAT + 2;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  dm_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_mem [16];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-array model: error from address rules, write merge via a byte mask.
  function automatic void model_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                       input logic [3:0] st, output logic [31:0] rd, output logic er);
    logic [31:0] mask;
    int unsigned w;
    er = (a % 4 != 0) || (a >= (32'd4 << DL));
    rd = 32'd0;
    mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    w = a / 4;
    if (!er && w < 16) begin
      if (wr) model_mem[w] = (model_mem[w] & ~mask) | (wd & mask);
      else    rd = model_mem[w];
    end
  endfunction

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                         input int hold, input logic [31:0] exp_rd, input logic exp_er);
    int lat;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = st; resp_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      req_wstrb = 4'($urandom); resp_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    check("latency", 32'(lat), 32'(LAT));
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_error", 32'(resp_error), 32'(exp_er));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_error", 32'(resp_error), 32'(exp_er));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_hs_valid", 32'(resp_valid), 32'd0);
    check("post_hs_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd, exp_rd, hs_data;
    logic [3:0]  st;
    logic        wr, exp_er, acc, hs;
    int          k_acc, k_hs, cyc, last_hs;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0012, 32'h0,         4'hF, 0, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 32'hA05A_C300, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 4'h0, 0, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 32'hA55A_C305, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 5, 32'hDE22_BE44, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 32'h0000_003C, 32'h0000_FFFF, 4'h3, 2, 32'h0000_0000, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_wstrb = 4'd0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      wd = {8'hA0 + 8'(i), 8'h5A, 8'hC3, 8'(i)};
      model_access(1'b1, 32'(i * 4), wd, 4'hF, exp_rd, exp_er);
      run_txn(1'b1, 32'(i * 4), wd, 4'hF, 0, 32'd0, 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      model_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, exp_rd, exp_er);
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].hold,
              vecs[i].exp_rd, vecs[i].exp_er);
    end

    // Reset one edge after accepting a write: it must be dropped.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midbusy_req_ready", 32'(req_ready), 32'd1);
    check("midbusy_resp_valid", 32'(resp_valid), 32'd0);
    check("midbusy_resp_rdata", resp_rdata, 32'd0);
    check("midbusy_resp_error", 32'(resp_error), 32'd0);
    @(posedge clk); #1;
    check("midbusy_held_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b0, 32'h20, 32'd0, 4'h0, 0, 32'hA85A_C308, 1'b0);

    for (int n = 0; n < 50; n++) begin
      wr = 1'($urandom);
      wd = $urandom;
      st = 4'($urandom);
      case ($urandom_range(0, 5))
        0: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        1: a = (32'($urandom_range(1, 1000)) << 12) | (32'($urandom_range(0, 1023)) << 2);
        default: a = 32'($urandom_range(0, 15)) << 2;
      endcase
      model_access(wr, a, wd, st, exp_rd, exp_er);
      run_txn(wr, a, wd, st, $urandom_range(0, 2), exp_rd, exp_er);
    end

    // Streamed reads with resp_ready held high: handshake spacing.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd0; req_wstrb = 4'd0; resp_ready = 1'b1;
    k_acc = 0; k_hs = 0; cyc = 0; last_hs = 0;
    while (k_hs < 4 && cyc < 100) begin
      acc = req_valid && req_ready;
      hs = resp_valid && resp_ready;
      hs_data = resp_rdata;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        check("stream_rdata", hs_data, model_mem[k_hs]);
        if (k_hs > 0) check("stream_period", 32'(cyc - last_hs), 32'(PERIOD));
        last_hs = cyc;
        k_hs++;
      end
      if (acc) begin
        k_acc++;
        if (k_acc < 4) req_addr = 32'(k_acc * 4);
        else req_valid = 1'b0;
      end
    end
    resp_ready = 1'b0;
    check("stream_count", 32'(k_hs), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
